// File: rtl/blinker_array.sv
// Multi-channel blink generator: per-channel OFF / ON / free-running BLINK / counted BURST.
// Optional BLINKER_ARRAY_SYNC_EN adds sync_in_i to realign all running channels.
module blinker_array #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 25,
  parameter int BURST_W  = 4,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
`ifdef BLINKER_ARRAY_SYNC_EN
  input  logic                sync_in_i,
`endif
  input  logic                cfg_valid_i,
  output logic                cfg_ready_o,
  input  logic [CH_W-1:0]     cfg_ch_i,
  input  logic [1:0]          cfg_mode_i,
  input  logic [CNT_W-1:0]    cfg_half_i,
  input  logic [BURST_W-1:0]  cfg_count_i,
  output logic [CHANNELS-1:0] blink_o,
  output logic [CHANNELS-1:0] busy_o,
  output logic [CHANNELS-1:0] done_o
);

  // S_OFF idle low | S_ON steady high | S_HI/S_LO running half-periods
  typedef enum logic [1:0] {S_OFF, S_ON, S_HI, S_LO} state_e;

  state_e               state_q [CHANNELS];
  state_e               state_d [CHANNELS];
  logic [CNT_W-1:0]     cnt_q   [CHANNELS];
  logic [CNT_W-1:0]     cnt_d   [CHANNELS];
  logic [CNT_W-1:0]     half_q  [CHANNELS];
  logic [CNT_W-1:0]     half_d  [CHANNELS];
  logic [BURST_W-1:0]   rem_q   [CHANNELS];
  logic [BURST_W-1:0]   rem_d   [CHANNELS];
  logic [CHANNELS-1:0]  burst_q, burst_d;
  logic [CHANNELS-1:0]  term_q, term_d;
  logic [CHANNELS-1:0]  blink_q, blink_d;
  logic [CHANNELS-1:0]  busy_q, busy_d;
  logic [CHANNELS-1:0]  done_q, done_d;
  logic                 ready_q, ready_d;
  logic                 wr_en;
  logic                 sync_w;

`ifdef BLINKER_ARRAY_SYNC_EN
  assign sync_w = sync_in_i;
`else
  assign sync_w = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_q <= 1'b0;
      blink_q <= '0;
      busy_q  <= '0;
      done_q  <= '0;
      term_q  <= '0;
      burst_q <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= S_OFF;
        cnt_q[c]   <= '0;
        half_q[c]  <= '0;
        rem_q[c]   <= '0;
      end
    end else begin
      ready_q <= ready_d;
      blink_q <= blink_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      term_q  <= term_d;
      burst_q <= burst_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      rem_q   <= rem_d;
    end
  end

  // Out-of-range channel writes are still handshaked so the controller never stalls.
  always_comb begin
    ready_d = !(cfg_valid_i && ready_q);
    wr_en   = cfg_valid_i && ready_q && (32'(cfg_ch_i) < 32'(CHANNELS));
    burst_d = burst_q;
    term_d  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      half_d[c]  = half_q[c];
      rem_d[c]   = rem_q[c];
      if (wr_en && (cfg_ch_i == CH_W'(c))) begin
        half_d[c]  = cfg_half_i;
        rem_d[c]   = cfg_count_i;
        cnt_d[c]   = '0;
        burst_d[c] = (cfg_mode_i == 2'b11);
        case (cfg_mode_i)
          2'b00: state_d[c] = S_OFF;
          2'b01: state_d[c] = S_ON;
          2'b10: state_d[c] = S_HI;
          default: begin
            if (cfg_count_i == '0) begin
              state_d[c] = S_OFF;
              term_d[c]  = 1'b1;
            end else begin
              state_d[c] = S_HI;
            end
          end
        endcase
      end else if ((state_q[c] == S_HI) || (state_q[c] == S_LO)) begin
        if (sync_w) begin
          state_d[c] = S_HI;
          cnt_d[c]   = '0;
        end else if (cnt_q[c] == half_q[c]) begin
          cnt_d[c] = '0;
          if (state_q[c] == S_HI) begin
            state_d[c] = S_LO;
          end else if (burst_q[c] && (rem_q[c] == BURST_W'(1))) begin
            state_d[c] = S_OFF;
            term_d[c]  = 1'b1;
          end else begin
            state_d[c] = S_HI;
            if (burst_q[c]) rem_d[c] = rem_q[c] - BURST_W'(1);
          end
        end else begin
          cnt_d[c] = cnt_q[c] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    blink_d = '0;
    busy_d  = '0;
    done_d  = term_q;
    for (int c = 0; c < CHANNELS; c++) begin
      blink_d[c] = (state_q[c] == S_ON) || (state_q[c] == S_HI);
      busy_d[c]  = (state_q[c] == S_HI) || (state_q[c] == S_LO);
    end
  end

  assign cfg_ready_o = ready_q;
  assign blink_o     = blink_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_blinker_array.sv
// Scoreboard bench for blinker_array: stimulus pushes per-edge expectations, a negedge monitor checks them.
module tb_blinker_array;
  localparam int CH = 6;
  localparam int CW = 3;
  localparam int CNT_W = 25;
  localparam int BW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_valid = 1'b0;
  logic cfg_ready;
  logic [CW-1:0] cfg_ch = '0;
  logic [1:0] cfg_mode = '0;
  logic [CNT_W-1:0] cfg_half = '0;
  logic [BW-1:0] cfg_count = '0;
  logic [CH-1:0] blink, busy, done;
`ifdef BLINKER_ARRAY_SYNC_EN
  logic sync_in = 1'b0;
`endif

  int edges_seen = 0;
  int vectors = 0;
  int misc = 0;
  int n0 = 0;

  typedef struct {
    int cyc;
    int ch;
    logic [2:0] ev;
    string nm;
  } exp_t;
  exp_t sbq[$];

  blinker_array #(.CHANNELS(CH), .CNT_W(CNT_W), .BURST_W(BW)) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
`ifdef BLINKER_ARRAY_SYNC_EN
    .sync_in_i(sync_in),
`endif
    .cfg_valid_i(cfg_valid),
    .cfg_ready_o(cfg_ready),
    .cfg_ch_i(cfg_ch),
    .cfg_mode_i(cfg_mode),
    .cfg_half_i(cfg_half),
    .cfg_count_i(cfg_count),
    .blink_o(blink),
    .busy_o(busy),
    .done_o(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges_seen <= edges_seen + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      misc++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", nm, edges_seen, act, req);
    end
  endtask

  // ch = -1 checks cfg_ready; otherwise ev = {blink, busy, done} of that channel
  task automatic push(input int cyc, input int ch, input logic [2:0] ev, input string nm);
    exp_t e;
    e.cyc = cyc; e.ch = ch; e.ev = ev; e.nm = nm;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    int samp;
    logic [2:0] act;
    samp = edges_seen;
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].cyc <= samp) begin
        if (sbq[i].cyc < samp) begin
          chk({sbq[i].nm, "_missed"}, 32'(sbq[i].cyc), 32'(samp));
        end else begin
          if (sbq[i].ch < 0) act = {2'b00, cfg_ready};
          else act = {blink[sbq[i].ch], busy[sbq[i].ch], done[sbq[i].ch]};
          chk(sbq[i].nm, 32'(act), 32'(sbq[i].ev));
        end
        sbq.delete(i);
      end
    end
  end

  function automatic logic [2:0] ch0_exp(input int e);
    return {(((e - n0 - 1) / 4) % 2) == 0, 1'b1, 1'b0};
  endfunction

  task automatic do_write(input int ch, input int mode, input int half, input int count,
                          output int n);
    int budget;
    budget = 0;
    @(negedge clk);
    while (!cfg_ready && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (!cfg_ready) chk("ready_timeout", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b1;
    cfg_ch = CW'(ch);
    cfg_mode = 2'(mode);
    cfg_half = CNT_W'(half);
    cfg_count = BW'(count);
    n = edges_seen + 1;
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("ready_drop", 32'(cfg_ready), 32'd0);
    push(n + 1, -1, 3'b001, "ready_back");
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (sbq.size() != 0 && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    if (sbq.size() != 0) begin
      chk("drain_timeout", 32'(sbq.size()), 32'd0);
      sbq.delete();
    end
  endtask

  initial begin
    int n, m;
    repeat (3) @(negedge clk);
    chk("rst_blink", 32'(blink), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(cfg_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_release", 32'(cfg_ready), 32'd0);
    push(edges_seen + 1, -1, 3'b001, "ready_up");
    drain();

    // ch0 BLINK half=3: 4 high, 4 low
    do_write(0, 2, 3, 0, n0);
    for (int k = 1; k <= 12; k++) push(n0 + k, 0, ch0_exp(n0 + k), "blink_ch0");
    drain();

    // ch1 BURST half=1 count=3 while ch0 keeps running
    do_write(1, 3, 1, 3, n);
    for (int k = 1; k <= 12; k++)
      push(n + k, 1, {(((k - 1) / 2) % 2) == 0, 1'b1, 1'b0}, "burst3_ch1");
    push(n + 13, 1, 3'b001, "burst3_done");
    push(n + 14, 1, 3'b000, "burst3_after");
    for (int k = 1; k <= 14; k++) push(n + k, 0, ch0_exp(n + k), "ch0_indep");
    drain();

    // ch2 BURST count=0: immediate done, never lights
    do_write(2, 3, 0, 0, n);
    push(n + 1, 2, 3'b001, "burst0_done");
    push(n + 2, 2, 3'b000, "burst0_after");
    push(n + 3, 2, 3'b000, "burst0_after");
    drain();

    // out-of-range channel: nothing changes
    do_write(7, 1, 5, 2, n);
    for (int k = 1; k <= 4; k++) begin
      push(n + k, 0, ch0_exp(n + k), "badch_ch0");
      for (int c = 1; c < CH; c++) push(n + k, c, 3'b000, "badch_other");
    end
    drain();

    // ch1 BURST count=5 aborted by ON after one pulse
    do_write(1, 3, 1, 5, n);
    for (int k = 1; k <= 4; k++)
      push(n + k, 1, {k <= 2, 1'b1, 1'b0}, "abort_pre");
    repeat (2) @(negedge clk);
    do_write(1, 1, 0, 0, m);
    chk("abort_accept_edge", 32'(m), 32'(n + 4));
    for (int k = 1; k <= 20; k++) push(m + k, 1, 3'b100, "abort_on");
    drain();

`ifdef BLINKER_ARRAY_SYNC_EN
    begin
      int a, b, s;
      do_write(0, 2, 2, 0, a);
      do_write(3, 2, 2, 0, b);
      @(negedge clk);
      sync_in = 1'b1;
      s = edges_seen + 1;
      for (int k = 1; k <= 12; k++) begin
        push(s + k, 0, {(((k - 1) / 3) % 2) == 0, 1'b1, 1'b0}, "sync_ch0");
        push(s + k, 3, {(((k - 1) / 3) % 2) == 0, 1'b1, 1'b0}, "sync_ch3");
        push(s + k, 1, 3'b100, "sync_on_kept");
      end
      @(negedge clk);
      sync_in = 1'b0;
      drain();
    end
`endif

    // asynchronous reset mid-operation
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_blink", 32'(blink), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_ready", 32'(cfg_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end
endmodule
